// File: rtl/arm_defs.sv
// Shared definitions for the ARM pipeline memory path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the SRAM controller FSM encoding, the data memory base address
// the CPU subtracts before the MEM stage, and the default SRAM width.
package arm_defs;

  typedef enum logic [1:0] {
    SRAM_IDLE = 2'd0,
    SRAM_LO   = 2'd1,
    SRAM_HI   = 2'd2,
    SRAM_DONE = 2'd3
  } sram_state_t;

  localparam int DATA_MEM_BASE   = 1024;
  localparam int SRAM_AW_DEFAULT = 18;

endpackage

// File: rtl/sram_controller.sv
// MEM-stage data memory front end: splits each 32-bit load/store into two
// 16-bit SRAM accesses (low halfword, then high), each WAIT+1 cycles long.
// Latency: 2*WAIT+3 stall cycles, then ready=1 for one DONE cycle;
// backpressure: ready=0 freezes the pipeline, and requests are ignored outside IDLE.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   rd_en, wr_en             load/store request (both high = store)
//   address, write_data      rebased byte address, store data
//   read_data                load result, held until the next load completes
//   ready                    0 = stall the pipeline
//   sram_addr                halfword address to the pad, held between accesses
//   sram_dq_out, sram_dq_oe  write data and its output enable
//   sram_dq_in               read data from the pad
//   sram_we_n                active-low write strobe
module sram_controller
  import arm_defs::*;
#(
  parameter int SRAM_AW = SRAM_AW_DEFAULT,
  parameter int WAIT    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_we_n
);

  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  sram_state_t state, next_state;
  logic [3:0]  cnt;
  logic        op_wr;
  logic [31:0] wdata;
  logic        req;
  logic        phase_end;

  assign req       = rd_en | wr_en;
  assign phase_end = (cnt == WAIT_CNT);

  // Only word-aligned accesses inside the SRAM window exist, so the byte
  // offset and the bits above the SRAM range carry no information.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{address[31:SRAM_AW+1], address[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SRAM_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state  = state;
    ready       = 1'b0;
    sram_we_n   = 1'b1;
    sram_dq_oe  = 1'b0;
    sram_dq_out = wdata[15:0];
    case (state)
      SRAM_IDLE: begin
        // A request arriving in IDLE must stall its own cycle.
        ready = ~req;
        if (req) next_state = SRAM_LO;
      end
      SRAM_LO: begin
        sram_we_n  = ~op_wr;
        sram_dq_oe = op_wr;
        if (phase_end) next_state = SRAM_HI;
      end
      SRAM_HI: begin
        sram_we_n   = ~op_wr;
        sram_dq_oe  = op_wr;
        sram_dq_out = wdata[31:16];
        if (phase_end) next_state = SRAM_DONE;
      end
      SRAM_DONE: begin
        ready      = 1'b1;
        next_state = SRAM_IDLE;
      end
      default: next_state = SRAM_IDLE;
    endcase
  end

  // sram_addr is a register so the pad address is stable for a whole phase
  // and keeps its last value in IDLE/DONE instead of falling back to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      op_wr     <= 1'b0;
      wdata     <= '0;
      sram_addr <= '0;
      read_data <= '0;
    end else begin
      case (state)
        SRAM_IDLE: begin
          cnt <= '0;
          if (req) begin
            op_wr     <= wr_en;
            wdata     <= write_data;
            sram_addr <= {address[SRAM_AW:2], 1'b0};
          end
        end
        SRAM_LO: begin
          if (phase_end) begin
            cnt          <= '0;
            sram_addr[0] <= 1'b1;
            if (!op_wr) read_data[15:0] <= sram_dq_in;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        SRAM_HI: begin
          if (phase_end) begin
            cnt <= '0;
            if (!op_wr) read_data[31:16] <= sram_dq_in;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
module tb_sram_controller;
  import arm_defs::*;

  localparam int AW = 18;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en      [2];
  logic        wr_en      [2];
  logic [31:0] address    [2];
  logic [31:0] write_data [2];
  logic [31:0] read_data  [2];
  logic        ready      [2];
  logic [AW-1:0] sram_addr [2];
  logic [15:0] dq_out     [2];
  logic        dq_oe      [2];
  logic [15:0] dq_in      [2];
  logic        we_n       [2];

  always #5 clk = ~clk;

  // Instance index equals its WAIT value.
  sram_controller #(.SRAM_AW(AW), .WAIT(0)) u_dut0 (
    .clk(clk), .rst(rst), .rd_en(rd_en[0]), .wr_en(wr_en[0]),
    .address(address[0]), .write_data(write_data[0]), .read_data(read_data[0]),
    .ready(ready[0]), .sram_addr(sram_addr[0]), .sram_dq_out(dq_out[0]),
    .sram_dq_oe(dq_oe[0]), .sram_dq_in(dq_in[0]), .sram_we_n(we_n[0]));

  sram_controller #(.SRAM_AW(AW), .WAIT(1)) u_dut1 (
    .clk(clk), .rst(rst), .rd_en(rd_en[1]), .wr_en(wr_en[1]),
    .address(address[1]), .write_data(write_data[1]), .read_data(read_data[1]),
    .ready(ready[1]), .sram_addr(sram_addr[1]), .sram_dq_out(dq_out[1]),
    .sram_dq_oe(dq_oe[1]), .sram_dq_in(dq_in[1]), .sram_we_n(we_n[1]));

  // Simple asynchronous-read SRAM pads, written on the clock edge while we_n is low.
  logic [15:0] sram0 [0:(1<<AW)-1];
  logic [15:0] sram1 [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (we_n[0] === 1'b0) sram0[sram_addr[0]] <= dq_out[0];
    if (we_n[1] === 1'b0) sram1[sram_addr[1]] <= dq_out[1];
  end
  assign dq_in[0] = sram0[sram_addr[0]];
  assign dq_in[1] = sram1[sram_addr[1]];

  // Reference model: word-addressed 32-bit memory per instance.
  logic [31:0] ref_mem [int];
  logic [31:0] last_rd [2];
  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int word_of(input logic [31:0] addr);
    return int'((addr >> 2) % (32'd1 << (AW - 1)));
  endfunction

  // Drives one access and watches the pad cycle by cycle: cycle 0 is the
  // request cycle, cycles 1..d+1 the low halfword, d+2..2d+2 the high one.
  task automatic do_access(input int d, input bit wr, input bit rd,
                           input logic [31:0] addr, input logic [31:0] data,
                           input bit drop, output int stall,
                           output logic [31:0] rdata, output int bus_errs);
    logic [AW-1:0] exp_addr;
    bit hi;
    @(negedge clk);
    rd_en[d] = rd; wr_en[d] = wr; address[d] = addr; write_data[d] = data;
    stall = 0; bus_errs = 0;
    #1;
    while (ready[d] !== 1'b1 && stall < 64) begin
      if (stall == 0) begin
        if (we_n[d] !== 1'b1 || dq_oe[d] !== 1'b0) bus_errs++;
      end else begin
        hi = (stall > d + 1);
        exp_addr = AW'(word_of(addr) * 2 + (hi ? 1 : 0));
        if (sram_addr[d] !== exp_addr) bus_errs++;
        if (we_n[d] !== !wr) bus_errs++;
        if (dq_oe[d] !== wr) bus_errs++;
        if (wr && dq_out[d] !== (hi ? data[31:16] : data[15:0])) bus_errs++;
      end
      stall++;
      @(negedge clk);
      if (drop && stall == 1) rd_en[d] = 1'b0;
      #1;
    end
    if (we_n[d] !== 1'b1 || dq_oe[d] !== 1'b0) bus_errs++;
    rdata = read_data[d];
    rd_en[d] = 1'b0; wr_en[d] = 1'b0;
  endtask

  task automatic op(input int d, input bit wr, input bit rd, input logic [31:0] addr,
                    input logic [31:0] data, input bit drop, input string tag);
    int stall, be, key;
    logic [31:0] rdata;
    key = d * (1 << 20) + word_of(addr);
    do_access(d, wr, rd, addr, data, drop, stall, rdata, be);
    chk({tag, " stall"}, 64'(stall), 64'(2 * d + 3));
    chk({tag, " bus"}, 64'(be), 64'd0);
    if (wr) begin
      ref_mem[key] = data;
      chk({tag, " rd_hold"}, 64'(rdata), 64'(last_rd[d]));
    end else begin
      chk({tag, " rdata"}, 64'(rdata), 64'(ref_mem[key]));
      last_rd[d] = ref_mem[key];
    end
  endtask

  initial begin
    logic [31:0] written [$];
    logic [31:0] a, v;
    int bad;

    for (int i = 0; i < 2; i++) begin
      rd_en[i] = 1'b0; wr_en[i] = 1'b0; address[i] = '0; write_data[i] = '0;
      last_rd[i] = '0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;

    // Reset state, idle with no request.
    for (int i = 0; i < 2; i++) begin
      chk("reset ready", 64'(ready[i]), 64'd1);
      chk("reset we_n", 64'(we_n[i]), 64'd1);
      chk("reset oe", 64'(dq_oe[i]), 64'd0);
      chk("reset read_data", 64'(read_data[i]), 64'd0);
      chk("reset sram_addr", 64'(sram_addr[i]), 64'd0);
    end

    // WAIT=1 directed write/read of 0xDEADBEEF at byte address 0x10.
    op(1, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, "w1 write 0x10");
    chk("w1 sram[8]", 64'(sram1[8]), 64'hBEEF);
    chk("w1 sram[9]", 64'(sram1[9]), 64'hDEAD);
    op(1, 1'b0, 1'b1, 32'h10, 32'h0, 1'b0, "w1 read 0x10");
    for (int i = 0; i < 4; i++) begin
      a = {$urandom_range(0, 8191), 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))} ^ 32'h0;
      v = $urandom;
      op(1, 1'b1, 1'b0, a, v, 1'b0, "w1 rand write");
      op(1, 1'b0, 1'b1, a ^ {12'($urandom), 20'h0} & 32'hFFF8_0000 | a & 32'h0007_FFFC, 32'h0, 1'b0, "w1 rand read");
    end

    // WAIT=0 back-to-back random traffic; ignored address bits are randomised.
    for (int i = 0; i < 6; i++) begin
      a = {13'($urandom), 17'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
      v = $urandom;
      op(0, 1'b1, 1'b0, a, v, 1'b0, "w0 seed write");
      written.push_back(a);
    end
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        a = {13'($urandom), 17'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
        v = $urandom;
        op(0, 1'b1, 1'b0, a, v, 1'b0, "w0 rand write");
        written.push_back(a);
      end else begin
        a = written[$urandom_range(0, written.size() - 1)];
        a = {13'($urandom), a[18:2], 2'($urandom_range(0, 3))};
        op(0, 1'b0, 1'b1, a, 32'h0, 1'b0, "w0 rand read");
      end
    end

    // Request dropped mid-access still completes; rd&wr together is a store.
    op(0, 1'b1, 1'b0, 32'h200, 32'h1234_5678, 1'b0, "drop prep write");
    op(0, 1'b0, 1'b1, 32'h200, 32'h0, 1'b1, "drop read");
    op(0, 1'b1, 1'b1, 32'h204, 32'hCAFE_F00D, 1'b0, "rdwr as write");
    op(0, 1'b0, 1'b1, 32'h204, 32'h0, 1'b0, "rdwr readback");

    // Reset during the high phase of a WAIT=1 write.
    @(negedge clk);
    wr_en[1] = 1'b1; address[1] = 32'h40; write_data[1] = 32'hA5A5_5A5A;
    @(negedge clk); wr_en[1] = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    chk("rst pre we_n", 64'(we_n[1]), 64'd0);
    chk("rst pre addr", 64'(sram_addr[1]), 64'h21);
    rst = 1'b1;
    #1;
    chk("rst we_n", 64'(we_n[1]), 64'd1);
    chk("rst oe", 64'(dq_oe[1]), 64'd0);
    chk("rst read_data", 64'(read_data[1]), 64'd0);
    chk("rst state", 64'(u_dut1.state), 64'(SRAM_IDLE));
    chk("rst sram_addr", 64'(sram_addr[1]), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      if (ready[1] !== 1'b1 || u_dut1.state === SRAM_DONE || we_n[1] !== 1'b1) bad++;
    end
    chk("rst no pulse", 64'(bad), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
